conv_stream_engine: RTL and testbench

CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

---
 rtl/conv_stream_engine_if.sv | 31 +++
 rtl/conv_stream_engine.sv | 116 +++++++++++
 tb/tb_conv_stream_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_engine_if.sv
// Frame handshake bundle for conv_stream_engine.
// Input frame + weights in, whole output frame out.
interface conv_stream_engine_if #(
  parameter int IMG_H  = 8,
  parameter int IMG_W  = 8,
  parameter int K      = 3,
  parameter int OUT_CH = 3,
  parameter int STRIDE = 1
);
  localparam int OH = (IMG_H - K) / STRIDE + 1;
  localparam int OW = (IMG_W - K) / STRIDE + 1;
  localparam int N  = OH * OW * OUT_CH;

  logic                          in_vld;
  logic                          in_rdy;
  logic [IMG_H*IMG_W*8-1:0]      data_lin;
  logic [K*K*OUT_CH*8-1:0]       weight_lin;
  logic [N*8-1:0]                conv_lin;
  logic                          out_vld;
  logic                          out_rdy;

  modport master (
    output in_vld, data_lin, weight_lin, out_rdy,
    input  in_rdy, conv_lin, out_vld
  );

  modport slave (
    input  in_vld, data_lin, weight_lin, out_rdy,
    output in_rdy, conv_lin, out_vld
  );
endinterface

// File: rtl/conv_stream_engine.sv
// Frame-based 2D convolution: one output element per cycle,
// K*K parallel multipliers, saturating 8-bit results.
module conv_stream_engine #(
  parameter int IMG_H  = 8,
  parameter int IMG_W  = 8,
  parameter int K      = 3,
  parameter int OUT_CH = 3,
  parameter int STRIDE = 1,
  parameter int SHIFT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_stream_engine_if.slave  bus
);
  localparam int DW    = 8;
  localparam int KK    = K * K;
  localparam int OH    = (IMG_H - K) / STRIDE + 1;
  localparam int OW    = (IMG_W - K) / STRIDE + 1;
  localparam int N     = OH * OW * OUT_CH;
  localparam int ACC_W = 16 + $clog2(KK);
  localparam int W     = $clog2(N + 1);

  localparam logic [W-1:0] C_LAST = W'(OW - 1);
  localparam logic [W-1:0] R_LAST = W'(OH - 1);
  localparam logic [W-1:0] I_LAST = W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [IMG_H*IMG_W*DW-1:0] data_q;
  logic [KK*OUT_CH*DW-1:0]   w_q;
  logic [N*DW-1:0]           conv_q;
  logic [W-1:0]              idx, ch, r, c;
  logic [ACC_W-1:0]          acc, sh;
  logic [DW-1:0]             px;
  logic                      in_rdy_c, out_vld_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_vld)    state_nx = RUN;
      RUN:     if (idx == I_LAST) state_nx = DONE;
      DONE:    if (bus.out_rdy)   state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_rdy_c  = 1'b0;
    out_vld_c = 1'b0;
    unique case (state)
      IDLE:    in_rdy_c  = 1'b1;
      DONE:    out_vld_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_rdy   = in_rdy_c;
  assign bus.out_vld  = out_vld_c;
  assign bus.conv_lin = conv_q;

  // Full K*K window for the current (ch,r,c) in one cycle.
  always_comb begin
    acc = '0;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        acc = acc
          + ACC_W'(data_q[((int'(r) * STRIDE + kr) * IMG_W
                   + int'(c) * STRIDE + kc) * DW +: DW])
          * ACC_W'(w_q[(int'(ch) * KK + kr * K + kc) * DW +: DW]);
      end
    end
  end

  assign sh = acc >> SHIFT;
  assign px = (|sh[ACC_W-1:DW]) ? {DW{1'b1}} : sh[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      w_q    <= '0;
      conv_q <= '0;
      idx    <= '0;
      ch     <= '0;
      r      <= '0;
      c      <= '0;
    end else if (state == IDLE && bus.in_vld) begin
      data_q <= bus.data_lin;
      w_q    <= bus.weight_lin;
      idx    <= '0;
      ch     <= '0;
      r      <= '0;
      c      <= '0;
    end else if (state == RUN) begin
      conv_q[int'(idx) * DW +: DW] <= px;
      idx <= idx + 1'b1;
      if (c == C_LAST) begin
        c <= '0;
        if (r == R_LAST) begin
          r  <= '0;
          ch <= ch + 1'b1;
        end else begin
          r <= r + 1'b1;
        end
      end else begin
        c <= c + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench: three engines (defaults, SHIFT=16, STRIDE=2)
// share one input stream; results checked against a frame model.
module tb_conv_stream_engine;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic         out_rdy = 1'b1;
  logic [511:0] data = '0;
  logic [215:0] wt = '0;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int l0, l1, l2, h0, cnt, done_cnt;
  logic [863:0] e0;
  logic seen, acc;

  always #5 clk = ~clk;

  conv_stream_engine_if #(.STRIDE(1)) b0 ();
  conv_stream_engine_if #(.STRIDE(1)) b1 ();
  conv_stream_engine_if #(.STRIDE(2)) b2 ();

  assign b0.in_vld = in_vld;
  assign b0.data_lin = data;
  assign b0.weight_lin = wt;
  assign b0.out_rdy = out_rdy;
  assign b1.in_vld = in_vld;
  assign b1.data_lin = data;
  assign b1.weight_lin = wt;
  assign b1.out_rdy = out_rdy;
  assign b2.in_vld = in_vld;
  assign b2.data_lin = data;
  assign b2.weight_lin = wt;
  assign b2.out_rdy = out_rdy;

  conv_stream_engine u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  conv_stream_engine #(.SHIFT(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  conv_stream_engine #(.STRIDE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  task automatic chk(input string tag,
                     input logic [863:0] obs,
                     input logic [863:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [863:0] frame_ref(
      input logic [511:0] d, input logic [215:0] w,
      input int st, input int shf);
    logic [863:0] res;
    longint s;
    int o;
    res = '0;
    o = (8 - 3) / st + 1;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < o; r++)
        for (int c = 0; c < o; c++) begin
          s = 0;
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
              s += longint'(d[((r*st+kr)*8 + c*st+kc)*8 +: 8])
                 * longint'(w[(ch*9 + kr*3 + kc)*8 +: 8]);
          s = s >> shf;
          res[((ch*o + r)*o + c)*8 +: 8] = (s > 255) ? 8'hff : 8'(s);
        end
    return res;
  endfunction

  task automatic start_frame();
    @(negedge clk);
    in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  // Cycle of first out_vld per engine, and out_vld high count of u0.
  task automatic measure(output int a0, output int a1,
                         output int a2, output int hi);
    a0 = -1; a1 = -1; a2 = -1; hi = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (b0.out_vld && a0 < 0) a0 = cyc;
      if (b1.out_vld && a1 < 0) a1 = cyc;
      if (b2.out_vld && a2 < 0) a2 = cyc;
      if (b0.out_vld) hi++;
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 6; i++) wt[i*32 +: 32] = $urandom;
    wt[215:192] = 24'($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", 864'(b0.in_rdy), 864'(1));
    chk("rst_out_vld", 864'(b0.out_vld), 864'(0));
    chk("rst_conv0", b0.conv_lin, '0);
    chk("rst_conv2", 864'(b2.conv_lin), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_rdy", 864'(b0.in_rdy), 864'(1));

    data = {64{8'd1}};
    wt = {27{8'd1}};
    start_frame();
    measure(l0, l1, l2, h0);
    chk("ones_lat0", 864'(l0), 864'(108));
    chk("ones_lat1", 864'(l1), 864'(108));
    chk("ones_lat2", 864'(l2), 864'(27));
    chk("ones_hi0", 864'(h0), 864'(1));
    chk("ones_conv0", b0.conv_lin, {108{8'd9}});
    chk("ones_conv1", b1.conv_lin, '0);
    chk("ones_conv2", 864'(b2.conv_lin), 864'({27{8'd9}}));

    data = {64{8'hff}};
    wt = {27{8'hff}};
    start_frame();
    measure(l0, l1, l2, h0);
    chk("sat_conv0", b0.conv_lin, {108{8'hff}});
    chk("shift_conv1", b1.conv_lin, {108{8'd8}});
    chk("sat_conv2", 864'(b2.conv_lin), 864'({27{8'hff}}));

    for (int i = 0; i < 64; i++) data[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 27; i++) wt[i*8 +: 8] = 8'(i / 9 + 1);
    start_frame();
    measure(l0, l1, l2, h0);
    chk("ramp_lat2", 864'(l2), 864'(27));
    chk("s2_ch0_00", 864'(b2.conv_lin[7:0]), 864'(81));
    chk("s2_ch1_00", 864'(b2.conv_lin[9*8 +: 8]), 864'(162));
    chk("s2_ch2_00", 864'(b2.conv_lin[18*8 +: 8]), 864'(243));
    chk("s2_ch2_22", 864'(b2.conv_lin[26*8 +: 8]), 864'(255));
    chk("s1_ch0_00", 864'(b0.conv_lin[7:0]), 864'(81));
    chk("ramp_conv0", b0.conv_lin, frame_ref(data, wt, 1, 0));
    chk("ramp_conv2", 864'(b2.conv_lin), frame_ref(data, wt, 2, 0));

    rand_frame();
    e0 = frame_ref(data, wt, 1, 0);
    out_rdy = 1'b0;
    start_frame();
    cnt = 0;
    while (!b0.out_vld && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("stall_reach", 864'(b0.out_vld), 864'(1));
    for (int i = 0; i < 20; i++) begin
      chk("stall_vld", 864'(b0.out_vld), 864'(1));
      chk("stall_conv", b0.conv_lin, e0);
      chk("stall_rdy", 864'(b0.in_rdy), 864'(0));
      in_vld = ~in_vld;
      data = ~data;
      @(negedge clk);
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("stall_rel_vld", 864'(b0.out_vld), 864'(0));
    chk("stall_rel_rdy", 864'(b0.in_rdy), 864'(1));
    chk("stall_keep", b0.conv_lin, e0);

    for (int i = 0; i < 64; i++) data[i*8 +: 8] = 8'(i);
    wt = {27{8'd1}};
    start_frame();
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_vld", 864'(b0.out_vld), 864'(0));
    chk("abort_conv", b0.conv_lin, '0);
    chk("abort_rdy", 864'(b0.in_rdy), 864'(1));
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (b0.out_vld) cnt++;
    end
    chk("abort_novld", 864'(cnt), 864'(0));
    start_frame();
    measure(l0, l1, l2, h0);
    chk("post_lat0", 864'(l0), 864'(108));
    chk("post_conv0", b0.conv_lin, frame_ref(data, wt, 1, 0));

    done_cnt = 0;
    for (int f = 0; f < 100; f++) begin
      rand_frame();
      e0 = frame_ref(data, wt, 1, 0);
      out_rdy = 1'b0;
      start_frame();
      seen = 1'b0;
      acc = 1'b0;
      for (int cyc = 0; cyc < 400 && !acc; cyc++) begin
        @(negedge clk);
        out_rdy = 1'($urandom_range(0, 1));
        if (b0.out_vld) begin
          if (!seen) chk("rand_conv", b0.conv_lin, e0);
          seen = 1'b1;
          if (out_rdy) acc = 1'b1;
        end
        @(posedge clk);
      end
      if (acc) done_cnt++;
      @(negedge clk);
      chk("rand_drop", 864'(b0.out_vld), 864'(0));
    end
    chk("rand_frames", 864'(done_cnt), 864'(100));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
